// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Write-side front end of the register file. ALU results (single cycle) and
//   load results (variable latency, buffered in a small FIFO) are merged onto
//   the single registered write port we/rd/wd.
//   Writes to x0 are consumed but never issued. A younger ALU result is held
//   back while an older load to the same register is still queued, so that
//   writes to one register happen in order (WAW).
//
//   Optional feature macro: WB_BYPASS_EN
//     Adds read-port forwarding (byp_rs1/2, rf_rd1/2 -> fwd_rd1/2). This covers
//     a register that is written and read in the same cycle.
//
//   Handshake: an item transfers on a rising edge where valid && ready are
//   both high. The producer keeps its fields stable while valid && !ready.
//   Neither ready depends on its own valid.
module reg_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  output logic            we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd,
`ifdef WB_BYPASS_EN
  input  logic [4:0]      byp_rs1,
  input  logic [4:0]      byp_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] fwd_rd1,
  output logic [XLEN-1:0] fwd_rd2,
`endif
  output logic            lsu_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;

  // Load FIFO storage. Each slot has a valid bit. The count is implied by
  // these bits, and the WAW scan only looks at live slots.
  logic [4:0]       mem_rd [DEPTH];
  logic [XLEN-1:0]  mem_wd [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  logic            full;
  logic            empty;
  logic            waw_hit;
  logic            push;
  logic            alu_take;
  logic            pop;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_wd;
  logic            issue;

  // Occupancy and WAW hazard against any queued load with the same rd.
  always_comb begin
    full    = &slot_valid;
    empty   = ~(|slot_valid);
    waw_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (mem_rd[i] == alu_rd) && (alu_rd != 5'd0))
        waw_hit = 1'b1;
    end
  end

  assign alu_ready   = !full && !waw_hit;
  assign lsu_ready   = !full;
  assign lsu_pending = !empty;

  // Write-port winner: a full FIFO drains first, then the ALU, then leftover loads.
  always_comb begin
    push     = lsu_valid && !full;
    alu_take = alu_valid && alu_ready;
    pop      = full || (!alu_take && !empty);
    sel_rd   = pop ? mem_rd[rptr] : alu_rd;
    sel_wd   = pop ? mem_wd[rptr] : alu_wd;
    issue    = (pop || alu_take) && (sel_rd != 5'd0);
  end

  // FIFO pointers, slot valid bits and the registered write port.
  // A push and a pop never hit the same slot, because a push needs !full.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      wptr       <= '0;
      rptr       <= '0;
      we         <= 1'b0;
      rd         <= 5'd0;
      wd         <= '0;
    end else begin
      if (pop) begin
        slot_valid[rptr] <= 1'b0;
        rptr             <= rptr + PTR_ONE;
      end
      if (push) begin
        slot_valid[wptr] <= 1'b1;
        wptr             <= wptr + PTR_ONE;
      end
      we <= issue;
      if (issue) begin
        rd <= sel_rd;
        wd <= sel_wd;
      end
    end
  end

  // FIFO payload. It is not reset, because slot_valid qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr] <= lsu_rd;
      mem_wd[wptr] <= lsu_wd;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the data being written this cycle to matching read ports.
  assign fwd_rd1 = (we && (rd != 5'd0) && (rd == byp_rs1)) ? wd : rf_rd1;
  assign fwd_rd2 = (we && (rd != 5'd0) && (rd == byp_rs2)) ? wd : rf_rd2;
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb_reg_writeback_arbiter
//   Bench for reg_writeback_arbiter. A queue-based model of the load FIFO and
//   the write priority is compared with the DUT on every falling edge.
//   Directed scenarios include literal expectations, followed by a
//   randomized run. Build with WB_BYPASS_EN to include the forwarding ports.
module tb_reg_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } item_t;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wd;
  logic            lsu_ready;
  logic            we;
  logic [4:0]      rd;
  logic [XLEN-1:0] wd;
  logic            lsu_pending;
`ifdef WB_BYPASS_EN
  logic [4:0]      byp_rs1;
  logic [4:0]      byp_rs2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] fwd_rd1;
  logic [XLEN-1:0] fwd_rd2;
`endif

  reg_writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .we(we), .rd(rd), .wd(wd),
`ifdef WB_BYPASS_EN
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
`endif
    .lsu_pending(lsu_pending)
  );

  // Model state: queued loads plus the expected write-port registers
  item_t           mq[$];
  item_t           wlog[$];
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  logic            alu_held;
  logic            lsu_held;
  int              errors = 0;
  int              checks = 0;

  function automatic logic model_alu_ready();
    logic ok;
    ok = (mq.size() < DEPTH);
    foreach (mq[i]) if (alu_rd != 5'd0 && mq[i].rd == alu_rd) ok = 1'b0;
    return ok;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then step past the rising edge.
  task automatic tick();
    logic            exp_ar;
    logic            exp_lr;
    logic            full;
    logic            alu_ok;
    logic            issue;
    logic [4:0]      nrd;
    logic [XLEN-1:0] nwd;
    item_t           it;
    @(negedge clk);
    exp_ar = model_alu_ready();
    exp_lr = (mq.size() < DEPTH);
    check("alu_ready", alu_ready, exp_ar);
    check("lsu_ready", lsu_ready, exp_lr);
    check("lsu_pending", lsu_pending, (mq.size() != 0));
    check("we", we, m_we);
    check("rd", rd, m_rd);
    check("wd", wd, m_wd);
`ifdef WB_BYPASS_EN
    check("fwd_rd1", fwd_rd1, (m_we && m_rd != 0 && m_rd == byp_rs1) ? m_wd : rf_rd1);
    check("fwd_rd2", fwd_rd2, (m_we && m_rd != 0 && m_rd == byp_rs2) ? m_wd : rf_rd2);
`endif
    if (we === 1'b1) begin
      it.rd = rd; it.wd = wd;
      wlog.push_back(it);
    end
    alu_held = alu_valid && !exp_ar && !rst;
    lsu_held = lsu_valid && !exp_lr && !rst;
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      full   = (mq.size() == DEPTH);
      alu_ok = alu_valid && exp_ar;
      issue  = 1'b0; nrd = '0; nwd = '0;
      if (full || (!alu_ok && mq.size() != 0)) begin
        it = mq.pop_front();
        issue = 1'b1; nrd = it.rd; nwd = it.wd;
      end else if (alu_ok) begin
        issue = 1'b1; nrd = alu_rd; nwd = alu_wd;
      end
      m_we = issue && (nrd != 5'd0);
      if (m_we) begin m_rd = nrd; m_wd = nwd; end
      if (lsu_valid && !full) begin
        it.rd = lsu_rd; it.wd = lsu_wd;
        mq.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [4:0]      e3_rd [4];
  logic [XLEN-1:0] e3_wd [4];
  item_t           loads[$];

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    alu_held = 1'b0; lsu_held = 1'b0;
`ifdef WB_BYPASS_EN
    byp_rs1 = '0; byp_rs2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    m_we = 1'b0; m_rd = '0; m_wd = '0;

    // Reset held for two cycles while an ALU result is offered
    alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h1234;
    tick(); tick();
    rst = 1'b0; alu_valid = 1'b0;
    #1;
    check("rst_we", we, 1'b0);
    check("rst_pending", lsu_pending, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b1);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check("alu_we", we, 1'b1);
    check("alu_rd", rd, 5'd5);
    check("alu_wd", wd, 32'hDEADBEEF);
    tick();
    check("alu_we_off", we, 1'b0);

    // Contention: ALU wins until the FIFO fills, then a forced pop
    wlog.delete();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h30;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      lsu_rd = 5'(10 + i); lsu_wd = 32'h40 + i; alu_wd = 32'h700 + i;
      tick();
      if (i == 0) begin
        check("cont_alu_wins_we", we, 1'b1);
        check("cont_alu_wins_rd", rd, 5'd7);
      end
    end
    lsu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!alu_held) alu_wd = 32'h710 + k;
      tick();
    end
    alu_valid = 1'b0;
    repeat (6) tick();
    e3_rd = '{5'd3, 5'd10, 5'd11, 5'd12};
    e3_wd = '{32'h30, 32'h40, 32'h41, 32'h42};
    loads.delete();
    foreach (wlog[i]) if (wlog[i].rd != 5'd7) loads.push_back(wlog[i]);
    check("cont_load_cnt", loads.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < loads.size()) begin
        check("cont_load_rd", loads[i].rd, e3_rd[i]);
        check("cont_load_wd", loads[i].wd, e3_wd[i]);
      end
    end

    // WAW: a queued load to rd=9 blocks an ALU write to rd=9
    wlog.delete();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h11;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h22;
    #1;
    check("waw_stall", alu_ready, 1'b0);
    tick();
    check("waw_release", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    repeat (2) tick();
    check("waw_cnt", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("waw_first", wlog[0].wd, 32'h11);
      check("waw_second", wlog[1].wd, 32'h22);
    end

    // x0 drop and pointer wrap: 10 loads rd 0..9
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_wd = 32'h500 + i;
      tick();
    end
    lsu_valid = 1'b0;
    repeat (4) tick();
    check("x0_cnt", wlog.size(), 9);
    check("x0_pending", lsu_pending, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < wlog.size()) check("x0_rd", wlog[i].rd, 5'(i + 1));
    end

    // Reset with three loads queued behind a busy ALU
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h77;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_wd = 32'h900 + i;
      tick();
    end
    lsu_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
    #1;
    check("mid_pending_pre", lsu_pending, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_pending", lsu_pending, 1'b0);
    check("mid_we", we, 1'b0);
    wlog.delete();
    repeat (4) tick();
    check("mid_no_write", wlog.size(), 0);

`ifdef WB_BYPASS_EN
    // Forwarding when the write and the read hit the same register
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'hCAFE0004;
    tick();
    alu_valid = 1'b0;
    byp_rs1 = 5'd4; rf_rd1 = 32'h1111; byp_rs2 = 5'd5; rf_rd2 = 32'h2222;
    #1;
    check("byp_hit", fwd_rd1, 32'hCAFE0004);
    check("byp_miss", fwd_rd2, 32'h2222);
    tick();
`endif

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!alu_held) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 7));
        alu_wd    = $urandom;
      end
      if (!lsu_held) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_wd    = $urandom;
      end
`ifdef WB_BYPASS_EN
      byp_rs1 = 5'($urandom_range(0, 7)); byp_rs2 = 5'($urandom_range(0, 7));
      rf_rd1 = $urandom; rf_rd2 = $urandom;
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
